// File: rtl/stepper_move_ctrl.sv
// ============================================================================
// Module   : stepper_move_ctrl
// Purpose  : Commanded-move controller for 4-wire unipolar steppers: issues a
//            counted number of wave/full/half steps at a programmable rate.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stepper_move_ctrl #(
    parameter int DIV_W = 32,
    parameter int CNT_W = 16,
    parameter int POS_W = 16,
    parameter bit HOLD  = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic [DIV_W-1:0] cmd_period,
    input  logic [1:0]       cmd_mode,
    input  logic             en,
    input  logic             stop,
    input  logic             zero_pos,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic             step_pulse,
    output logic [POS_W-1:0] position,
    output logic [3:0]       stepperPins
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [3:0]       c_rst_pins   = HOLD ? 4'b1000 : 4'b0000;
    localparam logic [DIV_W-1:0] c_min_period = DIV_W'(2);

    function automatic logic [3:0] phase_pins(input logic [2:0] idx);
        case (idx)
            3'd0:    phase_pins = 4'b1000;
            3'd1:    phase_pins = 4'b1100;
            3'd2:    phase_pins = 4'b0100;
            3'd3:    phase_pins = 4'b0110;
            3'd4:    phase_pins = 4'b0010;
            3'd5:    phase_pins = 4'b0011;
            3'd6:    phase_pins = 4'b0001;
            default: phase_pins = 4'b1001;
        endcase
    endfunction

    state_t           state_q,   state_d;
    logic [2:0]       idx_q,     idx_d;
    logic [POS_W-1:0] pos_q,     pos_d;
    logic [DIV_W-1:0] cnt_q,     cnt_d;
    logic [DIV_W-1:0] period_q,  period_d;
    logic [CNT_W-1:0] rem_q,     rem_d;
    logic             dir_q,     dir_d;
    logic             half_q,    half_d;
    logic             done_q,    done_d;
    logic             aborted_q, aborted_d;
    logic             step_q,    step_d;
    logic [3:0]       pins_q,    pins_d;

    logic       w_accept;
    logic       w_event;
    logic [2:0] w_delta;
    logic [2:0] w_next_idx;

    assign w_accept   = cmd_valid && (state_q == IDLE);
    assign w_event    = (state_q == RUN) && en && (cnt_q == period_q - DIV_W'(1));
    assign w_delta    = half_q ? 3'd1 : 3'd2;
    assign w_next_idx = dir_q ? (idx_q + w_delta) : (idx_q - w_delta);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pos_d     = pos_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        rem_d     = rem_q;
        dir_d     = dir_q;
        half_d    = half_q;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        step_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (zero_pos) begin
                    pos_d = '0;
                end
                if (w_accept) begin
                    dir_d    = cmd_dir;
                    half_d   = cmd_mode[1];
                    period_d = (cmd_period < c_min_period) ? c_min_period : cmd_period;
                    rem_d    = cmd_steps;
                    cnt_d    = '0;
                    // Snap onto the coil pattern family of the requested mode
                    if (cmd_mode == 2'b00) begin
                        idx_d[0] = 1'b0;
                    end else if (cmd_mode == 2'b01) begin
                        idx_d[0] = 1'b1;
                    end
                    if (cmd_steps == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            default: begin
                if (stop) begin
                    state_d   = IDLE;
                    done_d    = 1'b1;
                    aborted_d = 1'b1;
                end else if (w_event) begin
                    cnt_d  = '0;
                    idx_d  = w_next_idx;
                    pos_d  = dir_q ? (pos_q + POS_W'(1)) : (pos_q - POS_W'(1));
                    step_d = 1'b1;
                    if (rem_q <= CNT_W'(1)) begin
                        rem_d   = '0;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        rem_d = rem_q - CNT_W'(1);
                    end
                end else if (en) begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
        endcase
        pins_d = ((state_d == RUN) || HOLD) ? phase_pins(idx_d) : 4'b0000;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= IDLE;
            idx_q     <= 3'd0;
            pos_q     <= '0;
            cnt_q     <= '0;
            period_q  <= c_min_period;
            rem_q     <= '0;
            dir_q     <= 1'b0;
            half_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            step_q    <= 1'b0;
            pins_q    <= c_rst_pins;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pos_q     <= pos_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            rem_q     <= rem_d;
            dir_q     <= dir_d;
            half_q    <= half_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            step_q    <= step_d;
            pins_q    <= pins_d;
        end
    end

    assign cmd_ready   = (state_q == IDLE);
    assign busy        = (state_q == RUN);
    assign done        = done_q;
    assign aborted     = aborted_q;
    assign step_pulse  = step_q;
    assign position    = pos_q;
    assign stepperPins = pins_q;

endmodule

`default_nettype wire

// File: tb/tb_stepper_move_ctrl.sv
// ============================================================================
// Module   : tb_stepper_move_ctrl
// Purpose  : Directed, table-driven bench for stepper_move_ctrl (HOLD=1 and a
//            HOLD=0 / narrow-position twin driven with the same stimulus).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stepper_move_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_dir = 1'b0;
    logic [15:0] cmd_steps = '0;
    logic [31:0] cmd_period = '0;
    logic [1:0]  cmd_mode = '0;
    logic        en = 1'b1;
    logic        stop = 1'b0;
    logic        zero_pos = 1'b0;

    logic        cmd_ready0, busy0, done0, aborted0, step0;
    logic [15:0] pos0;
    logic [3:0]  pins0;
    logic        cmd_ready1, busy1, done1, aborted1, step1;
    logic [3:0]  pos1;
    logic [3:0]  pins1;

    always #5 clock = ~clock;

    stepper_move_ctrl #(.DIV_W(32), .CNT_W(16), .POS_W(16), .HOLD(1'b1)) u_hold (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready0),
        .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .cmd_period(cmd_period),
        .cmd_mode(cmd_mode), .en(en), .stop(stop), .zero_pos(zero_pos),
        .busy(busy0), .done(done0), .aborted(aborted0), .step_pulse(step0),
        .position(pos0), .stepperPins(pins0)
    );

    stepper_move_ctrl #(.DIV_W(32), .CNT_W(16), .POS_W(4), .HOLD(1'b0)) u_free (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready1),
        .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .cmd_period(cmd_period),
        .cmd_mode(cmd_mode), .en(en), .stop(stop), .zero_pos(zero_pos),
        .busy(busy1), .done(done1), .aborted(aborted1), .step_pulse(step1),
        .position(pos1), .stepperPins(pins1)
    );

    typedef struct {
        logic        rst_first;
        logic        dir;
        logic [15:0] steps;
        logic [31:0] period;
        logic [1:0]  mode;
        int          eff;
        logic [15:0] exp_pos;
        logic [3:0]  exp_pins;
    } vec_t;

    vec_t        vecs [8];
    int          total = 0;
    int          bad = 0;
    logic [2:0]  idx_m = 3'd0;
    logic [15:0] pos_m = '0;

    function automatic logic [3:0] pins_of(input logic [2:0] i);
        case (i)
            3'd0: return 4'b1000;
            3'd1: return 4'b1100;
            3'd2: return 4'b0100;
            3'd3: return 4'b0110;
            3'd4: return 4'b0010;
            3'd5: return 4'b0011;
            3'd6: return 4'b0001;
            default: return 4'b1001;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic model_align(input logic [1:0] mode);
        if (mode == 2'b00) idx_m[0] = 1'b0;
        else if (mode == 2'b01) idx_m[0] = 1'b1;
    endtask

    task automatic model_step(input logic dir, input logic half);
        logic [2:0] d;
        d = half ? 3'd1 : 3'd2;
        idx_m = dir ? idx_m + d : idx_m - d;
        pos_m = dir ? pos_m + 16'd1 : pos_m - 16'd1;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        cmd_valid = 1'b0;
        stop = 1'b0;
        zero_pos = 1'b0;
        en = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        idx_m = 3'd0;
        pos_m = '0;
    endtask

    task automatic issue(input logic dir, input logic [15:0] steps, input logic [31:0] per,
                         input logic [1:0] mode);
        cmd_dir = dir;
        cmd_steps = steps;
        cmd_period = per;
        cmd_mode = mode;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        model_align(mode);
    endtask

    task automatic run_vec(input vec_t v, input int n);
        int  nstep;
        bit  fin;
        int  limit;
        if (v.rst_first) apply_reset();
        issue(v.dir, v.steps, v.period, v.mode);
        if (v.steps == 16'd0) begin
            check($sformatf("v%0d_zero_done", n), {31'd0, done0}, 32'd1);
            check($sformatf("v%0d_zero_busy", n), {31'd0, busy0}, 32'd0);
            check($sformatf("v%0d_zero_step", n), {31'd0, step0}, 32'd0);
            check($sformatf("v%0d_zero_aborted", n), {31'd0, aborted0}, 32'd0);
        end else begin
            check($sformatf("v%0d_busy", n), {31'd0, busy0}, 32'd1);
            check($sformatf("v%0d_align_pins", n), {28'd0, pins0}, {28'd0, pins_of(idx_m)});
            check($sformatf("v%0d_align_pins_free", n), {28'd0, pins1}, {28'd0, pins_of(idx_m)});
            nstep = 0;
            fin = 1'b0;
            limit = int'(v.steps) * v.eff + 5;
            for (int k = 1; k <= limit && !fin; k++) begin
                tick();
                if (step0) begin
                    nstep++;
                    check($sformatf("v%0d_step%0d_time", n, nstep), k, nstep * v.eff);
                    model_step(v.dir, v.mode[1]);
                    check($sformatf("v%0d_step%0d_pins", n, nstep), {28'd0, pins0}, {28'd0, pins_of(idx_m)});
                end
                if (done0) begin
                    fin = 1'b1;
                    check($sformatf("v%0d_done_time", n), k, int'(v.steps) * v.eff);
                    check($sformatf("v%0d_nsteps", n), nstep, int'(v.steps));
                    check($sformatf("v%0d_aborted", n), {31'd0, aborted0}, 32'd0);
                end
            end
            if (!fin) check($sformatf("v%0d_done_timeout", n), 32'd0, 32'd1);
        end
        check($sformatf("v%0d_pos", n), {16'd0, pos0}, {16'd0, v.exp_pos});
        check($sformatf("v%0d_pins", n), {28'd0, pins0}, {28'd0, v.exp_pins});
        check($sformatf("v%0d_pos_narrow", n), {28'd0, pos1}, {28'd0, v.exp_pos[3:0]});
        check($sformatf("v%0d_idle_pins_free", n), {28'd0, pins1}, 32'd0);
        check($sformatf("v%0d_ready", n), {31'd0, cmd_ready0}, 32'd1);
        tick();
        check($sformatf("v%0d_done_drop", n), {31'd0, done0}, 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          exp_t [5];
        int          n;
        bit          fin;
        logic [3:0]  pins_hold;

        //         rst   dir   steps  period  mode eff pos       pins
        vecs[0] = '{1'b1, 1'b1, 16'd3, 32'd4, 2'd2, 4, 16'h0003, 4'b0110};
        vecs[1] = '{1'b1, 1'b0, 16'd2, 32'd2, 2'd1, 2, 16'hFFFE, 4'b0011};
        vecs[2] = '{1'b0, 1'b1, 16'd3, 32'd3, 2'd0, 3, 16'h0001, 4'b0100};
        vecs[3] = '{1'b0, 1'b0, 16'd0, 32'd5, 2'd1, 5, 16'h0001, 4'b0110};
        vecs[4] = '{1'b0, 1'b1, 16'd2, 32'd0, 2'd2, 2, 16'h0003, 4'b0011};
        vecs[5] = '{1'b0, 1'b0, 16'd1, 32'd1, 2'd3, 2, 16'h0002, 4'b0010};
        vecs[6] = '{1'b0, 1'b1, 16'd4, 32'd2, 2'd0, 2, 16'h0006, 4'b0010};
        vecs[7] = '{1'b0, 1'b1, 16'd3, 32'd2, 2'd0, 2, 16'h0009, 4'b0100};

        // Reset values
        reset = 1'b0;
        tick();
        tick();
        check("rst_ready", {31'd0, cmd_ready0}, 32'd1);
        check("rst_busy", {31'd0, busy0}, 32'd0);
        check("rst_done", {31'd0, done0}, 32'd0);
        check("rst_aborted", {31'd0, aborted0}, 32'd0);
        check("rst_step", {31'd0, step0}, 32'd0);
        check("rst_pos", {16'd0, pos0}, 32'd0);
        check("rst_pins_hold", {28'd0, pins0}, 32'h8);
        check("rst_pins_free", {28'd0, pins1}, 32'h0);
        reset = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Pause mid-move: pins and count freeze, counting resumes from held value
        exp_t = '{4, 8, 22, 26, 30};
        issue(1'b1, 16'd5, 32'd4, 2'd2);
        n = 0;
        fin = 1'b0;
        pins_hold = 4'b0;
        for (int k = 1; k <= 60 && !fin; k++) begin
            tick();
            if (step0) begin
                if (n < 5) check("en_pulse_time", k, exp_t[n]);
                n++;
                model_step(1'b1, 1'b1);
            end
            if (k == 19) check("en_pins_frozen", {28'd0, pins0}, {28'd0, pins_hold});
            if (k == 15) check("en_busy_paused", {31'd0, busy0}, 32'd1);
            if (k == 9) pins_hold = pins0;
            if (done0) begin
                fin = 1'b1;
                check("en_done_time", k, 30);
                check("en_nsteps", n, 5);
            end
            en = (k < 9 || k >= 19);
        end
        if (!fin) check("en_done_timeout", 32'd0, 32'd1);
        en = 1'b1;
        check("en_pos", {16'd0, pos0}, 32'd14);
        check("en_pins", {28'd0, pins0}, {28'd0, pins_of(idx_m)});
        tick();

        // Stop coincident with the second step event; queued command taken on done
        issue(1'b1, 16'd4, 32'd3, 2'd2);
        tick();
        tick();
        tick();
        check("stop_first_step", {31'd0, step0}, 32'd1);
        model_step(1'b1, 1'b1);
        tick();
        tick();
        stop = 1'b1;
        cmd_valid = 1'b1;
        cmd_dir = 1'b0;
        cmd_steps = 16'd1;
        cmd_period = 32'd2;
        cmd_mode = 2'd2;
        tick();
        stop = 1'b0;
        check("stop_done", {31'd0, done0}, 32'd1);
        check("stop_aborted", {31'd0, aborted0}, 32'd1);
        check("stop_no_step", {31'd0, step0}, 32'd0);
        check("stop_busy", {31'd0, busy0}, 32'd0);
        check("stop_pos", {16'd0, pos0}, 32'd15);
        check("stop_ready", {31'd0, cmd_ready0}, 32'd1);
        tick();
        cmd_valid = 1'b0;
        check("stop_reaccept_busy", {31'd0, busy0}, 32'd1);
        check("stop_reaccept_done_low", {31'd0, done0}, 32'd0);
        fin = 1'b0;
        for (int k = 1; k <= 10 && !fin; k++) begin
            tick();
            if (done0) begin
                fin = 1'b1;
                model_step(1'b0, 1'b1);
                check("stop_next_time", k, 2);
                check("stop_next_step", {31'd0, step0}, 32'd1);
                check("stop_next_aborted", {31'd0, aborted0}, 32'd0);
            end
        end
        if (!fin) check("stop_next_timeout", 32'd0, 32'd1);
        check("stop_next_pos", {16'd0, pos0}, 32'd14);
        check("stop_next_pins", {28'd0, pins0}, 32'h9);

        // stop in IDLE is ignored
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("idle_stop_done", {31'd0, done0}, 32'd0);
        check("idle_stop_ready", {31'd0, cmd_ready0}, 32'd1);

        // zero_pos ignored while running, honoured in IDLE
        issue(1'b1, 16'd2, 32'd3, 2'd2);
        tick();
        zero_pos = 1'b1;
        tick();
        zero_pos = 1'b0;
        fin = 1'b0;
        for (int k = 0; k < 20 && !fin; k++) begin
            tick();
            if (done0) fin = 1'b1;
        end
        if (!fin) check("zero_run_timeout", 32'd0, 32'd1);
        check("zero_run_ignored", {16'd0, pos0}, 32'd16);
        zero_pos = 1'b1;
        tick();
        zero_pos = 1'b0;
        check("zero_idle_pos", {16'd0, pos0}, 32'd0);
        check("zero_idle_pos_narrow", {28'd0, pos1}, 32'd0);
        check("zero_idle_pins_free", {28'd0, pins1}, 32'd0);

        // Reset in the middle of a move
        issue(1'b1, 16'd5, 32'd2, 2'd0);
        tick();
        tick();
        tick();
        check("mid_busy", {31'd0, busy0}, 32'd1);
        reset = 1'b0;
        tick();
        check("mid_rst_busy", {31'd0, busy0}, 32'd0);
        check("mid_rst_ready", {31'd0, cmd_ready0}, 32'd1);
        check("mid_rst_done", {31'd0, done0}, 32'd0);
        check("mid_rst_aborted", {31'd0, aborted0}, 32'd0);
        check("mid_rst_step", {31'd0, step0}, 32'd0);
        check("mid_rst_pos", {16'd0, pos0}, 32'd0);
        check("mid_rst_pins_hold", {28'd0, pins0}, 32'h8);
        check("mid_rst_pins_free", {28'd0, pins1}, 32'h0);
        reset = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
